// File: rtl/mem_access_unit.sv
// Memory-stage bus access unit: turns EX/MEM load/store requests into a registered
// req/ack bus transaction, stalls the pipeline until it completes and formats load data.
module mem_access_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] O_outEXMEM,
    input  logic [31:0] o_RT_DataEXMEM,
    input  logic        re_inEXMEM,
    input  logic        we_inEXMEM,
    input  logic [1:0]  size_inEXMEM,
    input  logic        lhunsigned_outEXMEM,
    input  logic        lhsigned_outEXMEM,
    input  logic        lbunsigned_outEXMEM,
    input  logic        lbsigned_outEXMEM,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        access_err
);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        req_q, req_d, we_q, we_d, valid_q, valid_d, err_q, err_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d, ldata_q, ldata_d;
    logic [3:0]  be_q, be_d;
    logic [1:0]  lo_q, lo_d, sz_q, sz_d;
    logic        sext_q, sext_d;

    logic access, is_half, is_byte, is_word, misaligned;
    logic unused_ext;

    // Unsigned selects only restate the default zero extension.
    assign unused_ext = lhunsigned_outEXMEM ^ lbunsigned_outEXMEM;

    assign access     = re_inEXMEM | we_inEXMEM;
    assign is_half    = (size_inEXMEM == SZ_HALF);
    assign is_byte    = (size_inEXMEM == SZ_BYTE);
    assign is_word    = !is_half && !is_byte;
    assign misaligned = (is_half && O_outEXMEM[0]) || (is_word && (O_outEXMEM[1:0] != 2'b00));

    assign stall = ((state_q == ST_IDLE) && access) || (state_q == ST_WAIT);

    function automatic logic [31:0] fmt_load(input logic [31:0] rd, input logic [1:0] lo,
                                             input logic [1:0] sz, input logic sext);
        logic [7:0]  b;
        logic [15:0] h;
        b = rd[{lo, 3'b000} +: 8];
        h = lo[1] ? rd[31:16] : rd[15:0];
        case (sz)
            SZ_BYTE: return {{24{sext & b[7]}}, b};
            SZ_HALF: return {{16{sext & h[15]}}, h};
            default: return rd;
        endcase
    endfunction

    always_comb begin
        // NOTE: every variable gets a default first, so no path can infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        ldata_d = ldata_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        lo_d    = lo_q;
        sz_d    = sz_q;
        sext_d  = sext_q;

        unique case (state_q)
            ST_IDLE: begin
                if (access) begin
                    lo_d   = O_outEXMEM[1:0];
                    sz_d   = size_inEXMEM;
                    sext_d = is_byte ? lbsigned_outEXMEM : (is_half && lhsigned_outEXMEM);
                    if (misaligned) begin
                        state_d = ST_DONE;
                        valid_d = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = 8'd0;
                        req_d   = 1'b1;
                        we_d    = we_inEXMEM;
                        addr_d  = {O_outEXMEM[31:2], 2'b00};
                        if (is_word) begin
                            be_d    = 4'b1111;
                            wdata_d = o_RT_DataEXMEM;
                        end else if (is_half) begin
                            be_d    = O_outEXMEM[1] ? 4'b1100 : 4'b0011;
                            wdata_d = {2{o_RT_DataEXMEM[15:0]}};
                        end else begin
                            be_d    = 4'b0001 << O_outEXMEM[1:0];
                            wdata_d = {4{o_RT_DataEXMEM[7:0]}};
                        end
                    end
                end
            end
            ST_WAIT: begin
                if (mem_ack) begin
                    state_d = ST_DONE;
                    req_d   = 1'b0;
                    valid_d = 1'b1;
                    ldata_d = we_q ? 32'd0 : fmt_load(mem_rdata, lo_q, sz_q, sext_q);
                end else if (cnt_q == WAIT_LAST) begin
                    state_d = ST_DONE;
                    req_d   = 1'b0;
                    valid_d = 1'b1;
                    err_d   = 1'b1;
                    ldata_d = 32'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            be_q    <= 4'b0000;
            ldata_q <= 32'd0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            lo_q    <= 2'b00;
            sz_q    <= 2'b00;
            sext_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            ldata_q <= ldata_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            lo_q    <= lo_d;
            sz_q    <= sz_d;
            sext_q  <= sext_d;
        end
    end

    assign mem_req    = req_q;
    assign mem_we     = we_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign mem_be     = be_q;
    assign load_data  = ldata_q;
    assign load_valid = valid_q;
    assign access_err = err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed corner cases, a mid-wait reset,
// then randomized accesses checked against an arithmetic reference model.
module tb_mem_access_unit;

    localparam int TO = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] O_outEXMEM, o_RT_DataEXMEM;
    logic        re_inEXMEM, we_inEXMEM;
    logic [1:0]  size_inEXMEM;
    logic        lhunsigned_outEXMEM, lhsigned_outEXMEM, lbunsigned_outEXMEM, lbsigned_outEXMEM;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        stall;
    logic [31:0] load_data;
    logic        load_valid, access_err;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_ld   = 32'd0;

    mem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clock              (clock),
        .reset              (reset),
        .O_outEXMEM         (O_outEXMEM),
        .o_RT_DataEXMEM     (o_RT_DataEXMEM),
        .re_inEXMEM         (re_inEXMEM),
        .we_inEXMEM         (we_inEXMEM),
        .size_inEXMEM       (size_inEXMEM),
        .lhunsigned_outEXMEM(lhunsigned_outEXMEM),
        .lhsigned_outEXMEM  (lhsigned_outEXMEM),
        .lbunsigned_outEXMEM(lbunsigned_outEXMEM),
        .lbsigned_outEXMEM  (lbsigned_outEXMEM),
        .mem_req            (mem_req),
        .mem_we             (mem_we),
        .mem_addr           (mem_addr),
        .mem_wdata          (mem_wdata),
        .mem_be             (mem_be),
        .mem_ack            (mem_ack),
        .mem_rdata          (mem_rdata),
        .stall              (stall),
        .load_data          (load_data),
        .load_valid         (load_valid),
        .access_err         (access_err)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ext = {lhunsigned, lhsigned, lbunsigned, lbsigned}
    function automatic logic [31:0] model_load(input logic [31:0] rd, input logic [31:0] a,
                                               input logic [1:0] sz, input logic [3:0] ext);
        int          lo;
        logic [31:0] v;
        lo = int'(a % 4);
        if (sz == 2'b10) begin
            v = (rd >> (8 * lo)) & 32'hFF;
            if (ext[0] && v >= 32'h80) v = v | 32'hFFFF_FF00;
        end else if (sz == 2'b01) begin
            v = (lo >= 2) ? (rd >> 16) : (rd & 32'hFFFF);
            if (ext[2] && v >= 32'h8000) v = v | 32'hFFFF_0000;
        end else begin
            v = rd;
        end
        return v;
    endfunction

    // Entered and left on a falling edge with the DUT idle.
    task automatic run_access(input logic [31:0] a, input logic [31:0] wd, input logic re,
                              input logic we, input logic [1:0] sz, input logic [3:0] ext,
                              input int ack_dly, input logic [31:0] rd);
        bit          word, half, mis, acked;
        int          lo, waited, stalls;
        logic [3:0]  ebe;
        logic [31:0] ewd, eaddr;
        word  = (sz == 2'b00) || (sz == 2'b11);
        half  = (sz == 2'b01);
        lo    = int'(a % 4);
        mis   = (word && lo != 0) || (half && (lo % 2) == 1);
        ebe   = word ? 4'hF : half ? ((lo >= 2) ? 4'hC : 4'h3) : 4'(1 << lo);
        ewd   = word ? wd : half ? (wd & 32'hFFFF) * 32'h0001_0001 : (wd & 32'hFF) * 32'h0101_0101;
        eaddr = a - 32'(lo);

        O_outEXMEM = a; o_RT_DataEXMEM = wd; re_inEXMEM = re; we_inEXMEM = we; size_inEXMEM = sz;
        {lhunsigned_outEXMEM, lhsigned_outEXMEM, lbunsigned_outEXMEM, lbsigned_outEXMEM} = ext;
        mem_ack = 1'($urandom % 2); mem_rdata = $urandom;
        #1;
        stalls = int'(stall);
        check("stall_idle", stall, 1);
        @(negedge clock);
        re_inEXMEM = 1'b0; we_inEXMEM = 1'b0;
        O_outEXMEM = $urandom; o_RT_DataEXMEM = $urandom; size_inEXMEM = 2'($urandom);

        if (mis) begin
            check("mis_req", mem_req, 0);
            check("mis_valid", load_valid, 1);
            check("mis_err", access_err, 1);
            check("mis_stall", stall, 0);
            check("mis_hold", load_data, exp_ld);
        end else begin
            waited = 0;
            acked  = 1'b0;
            while (!acked && waited < TO) begin
                check("req", mem_req, 1);
                check("addr", mem_addr, eaddr);
                check("be", mem_be, ebe);
                check("we", mem_we, we);
                if (we) check("wdata", mem_wdata, ewd);
                check("wait_valid", load_valid, 0);
                check("wait_err", access_err, 0);
                mem_ack   = (waited == ack_dly);
                mem_rdata = mem_ack ? rd : $urandom;
                #1;
                stalls += int'(stall);
                @(negedge clock);
                acked = (waited == ack_dly);
                waited++;
            end
            mem_ack = 1'($urandom % 2); mem_rdata = $urandom;
            exp_ld = (acked && !we) ? model_load(rd, a, sz, ext) : 32'd0;
            check("done_req", mem_req, 0);
            check("done_valid", load_valid, 1);
            check("done_err", access_err, !acked);
            check("load_data", load_data, exp_ld);
            check("done_stall", stall, 0);
            check("stall_cycles", stalls, 1 + waited);
        end

        @(negedge clock);
        check("idle_valid", load_valid, 0);
        check("idle_err", access_err, 0);
        check("idle_req", mem_req, 0);
        check("hold_data", load_data, exp_ld);
    endtask

    task automatic reset_mid_wait();
        O_outEXMEM = 32'h300; o_RT_DataEXMEM = 32'd0; re_inEXMEM = 1'b1; we_inEXMEM = 1'b0;
        size_inEXMEM = 2'b00; mem_ack = 1'b0;
        @(negedge clock);
        re_inEXMEM = 1'b0;
        check("rst_req_pre", mem_req, 1);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("rst_req_drop", mem_req, 0);
        check("rst_stall", stall, 0);
        check("rst_valid", load_valid, 0);
        check("rst_data", load_data, 0);
        exp_ld = 32'd0;
        mem_ack = 1'b1; mem_rdata = $urandom;
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            check("rst_no_pulse", load_valid, 0);
        end
        reset = 1'b1;
        run_access(32'h308, 32'd0, 1'b1, 1'b0, 2'b01, 4'b0100, 1, 32'h8001_7FFF);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        O_outEXMEM = 32'd0; o_RT_DataEXMEM = 32'd0; re_inEXMEM = 1'b0; we_inEXMEM = 1'b0;
        size_inEXMEM = 2'b00;
        {lhunsigned_outEXMEM, lhsigned_outEXMEM, lbunsigned_outEXMEM, lbsigned_outEXMEM} = 4'b0;
        mem_ack = 1'b0; mem_rdata = 32'd0;
        #2 reset = 1'b0;
        repeat (2) @(negedge clock);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_mem_be", mem_be, 0);
        check("rst_load_data", load_data, 0);
        check("rst_load_valid", load_valid, 0);
        check("rst_access_err", access_err, 0);
        check("rst_stall", stall, 0);
        reset = 1'b1;

        run_access(32'h100, 32'd0, 1'b1, 1'b0, 2'b00, 4'b0000, 0, 32'hDEAD_BEEF);
        run_access(32'h103, 32'd0, 1'b1, 1'b0, 2'b10, 4'b0001, 0, 32'h80FF_0000);
        run_access(32'h103, 32'd0, 1'b1, 1'b0, 2'b10, 4'b0010, 0, 32'h80FF_0000);
        run_access(32'h202, 32'h1234_ABCD, 1'b0, 1'b1, 2'b01, 4'b0000, 1, $urandom);
        run_access(32'h101, 32'd0, 1'b1, 1'b0, 2'b00, 4'b0000, 0, 32'd0);
        run_access(32'h040, 32'd0, 1'b1, 1'b0, 2'b00, 4'b0000, 100, 32'd0);
        run_access(32'h044, 32'hCAFE_F00D, 1'b1, 1'b1, 2'b11, 4'b0000, 2, 32'h5555_AAAA);
        run_access(32'h046, 32'd0, 1'b1, 1'b0, 2'b01, 4'b0100, TO - 1, 32'h8123_4567);
        reset_mid_wait();

        for (int i = 0; i < 300; i++) begin
            logic [1:0] rw;
            rw = 2'(1 + $urandom % 3);
            run_access($urandom, $urandom, rw[0], rw[1], 2'($urandom), 4'($urandom),
                       int'($urandom % (TO + 2)), $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255 (range 1..255): maximum WAIT-state cycles before the bus access is abandoned.
REQ-002 SHALL have ports: clock  input  1  sole clock, rising edge.
REQ-003 reset  input  1  asynchronous, active-low (0 = reset).
REQ-004 O_outEXMEM  input  32  access byte address from EX/MEM.
REQ-005 o_RT_DataEXMEM  input  32  store data from EX/MEM.
REQ-006 re_inEXMEM, we_inEXMEM  input  1 each  load / store request.
REQ-007 size_inEXMEM  input  2  00 word, 01 half, 10 byte, 11 treated as word.
REQ-008 lhunsigned_outEXMEM, lhsigned_outEXMEM, lbunsigned_outEXMEM, lbsigned_outEXMEM  input  1 each  load extension select.
REQ-009 mem_req  output  1; mem_we  output  1; mem_addr  output  32; mem_wdata  output  32; mem_be  output  4: bus request, all registered.
REQ-010 mem_ack  input  1; mem_rdata  input  32: bus response, valid when mem_ack=1.
REQ-011 stall  output  1  combinational, freezes PC/IF/ID/EX and EX/MEM.
REQ-012 load_data  output  32; load_valid  output  1; access_err  output  1: registered results toward MEM/WB.

Function
REQ-013 SHALL implement FSM states IDLE, WAIT, DONE.
REQ-014 access = re_inEXMEM | we_inEXMEM; on both high, the access SHALL be a store and the read SHALL be ignored.
REQ-015 stall SHALL be 1 when (IDLE & access) or WAIT, else 0; stall SHALL be 0 in DONE.
REQ-016 IDLE, access, aligned: next state WAIT; mem_req<=1; mem_we<=store; mem_addr<={addr[31:2],2'b00}; mem_be and mem_wdata latched.
REQ-017 Misaligned = half with addr[0]=1, or word with addr[1:0]!=0; IDLE & access & misaligned -> DONE, no bus request, access_err<=1.
REQ-018 mem_be: word 1111; half 0011 (addr[1]=0) / 1100 (addr[1]=1); byte 0001<<addr[1:0].
REQ-019 mem_wdata: word as-is; half {2{rt[15:0]}}; byte {4{rt[7:0]}}.
REQ-020 mem_addr, mem_we, mem_be, mem_wdata SHALL stay stable while mem_req=1.
REQ-021 WAIT & mem_ack: mem_req<=0; DONE; load: load_data<=formatted mem_rdata; store: load_data<=0.
REQ-022 Load format: select byte mem_rdata[8*addr[1:0]+7 -: 8] or half by addr[1]; lbsigned/lhsigned sign-extend; lbunsigned/lhunsigned or no flag zero-extend; word unchanged.
REQ-023 WAIT counter (8 bits) SHALL clear on entry, increment per cycle without ack; at TIMEOUT_CYCLES without ack: mem_req<=0, access_err<=1, load_data<=0, DONE.
REQ-024 mem_ack outside WAIT SHALL be ignored.
REQ-025 DONE: load_valid=1 for exactly one cycle (both loads and stores), access_err held from entry; next state IDLE unconditionally; no new access accepted in DONE.
REQ-026 load_valid and access_err SHALL be 0 in IDLE and WAIT; load_data holds last value.
REQ-027 Latency: access in cycle N, mem_req high cycle N+1; ack in cycle M -> DONE cycle M+1; minimum stall 2 cycles.

Reset
REQ-028 reset=0 SHALL immediately force IDLE, counter 0, mem_req, mem_we, load_valid, access_err 0, mem_addr, mem_wdata, load_data 0, mem_be 0000.
REQ-029 Reset mid-WAIT SHALL drop mem_req at once; no DONE pulse afterwards.
REQ-030 First access SHALL be accepted in the first rising edge after reset deasserts.

Verification
REQ-031 Word load addr 0x100, ack 1 cycle after req, rdata 0xDEADBEEF -> mem_be 1111, stall 2 cycles, load_data 0xDEADBEEF, load_valid 1 cycle.
REQ-032 lbsigned addr 0x103, rdata 0x80FF_0000 -> mem_be 0001<<3=1000, load_data 0xFFFFFF80; lbunsigned same -> 0x00000080.
REQ-033 Store half addr 0x202, rt 0x1234ABCD -> mem_we 1, mem_be 1100, mem_wdata 0xABCDABCD, mem_addr 0x200.
REQ-034 Word load addr 0x101 -> no mem_req, stall 1 cycle, DONE with access_err 1, load_valid 1.
REQ-035 TIMEOUT_CYCLES=4, no ack -> mem_req drops after 4 WAIT cycles, access_err 1, load_data 0.
REQ-036 reset=0 in second WAIT cycle -> mem_req 0 same cycle, no load_valid; next access after release proceeds normally.
